// File: rtl/decode_operand_fetch.sv
// Decode/operand-fetch stage: splits instruction words, performs the data read for
// ADD/SUB/LOAD, and presents the decoded word to execute over valid/ready.
module decode_operand_fetch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [7:0]  if_pc,
  output logic        if_ready,
  output logic        mem_rd_req,
  output logic [7:0]  mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [15:0] mem_rd_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [7:0]  OP_code,
  output logic [7:0]  value,
  output logic [15:0] MAR,
  output logic [15:0] MBR,
  output logic [7:0]  ex_pc,
  output logic        halt_program,
  output logic        illegal_op,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_LOAD = 8'h03;
  localparam logic [7:0] OP_LAST = 8'h07;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       accept;
  logic [7:0] opcode;
  logic [7:0] operand;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD);
  endfunction

  assign opcode   = if_instr[15:8];
  assign operand  = if_instr[7:0];
  assign if_ready = rst & ~flush & (state == IDLE) & (~ex_valid | ex_ready);
  assign accept   = if_valid & if_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= 8'h00;
      ex_valid     <= 1'b0;
      OP_code      <= 8'h00;
      value        <= 8'h00;
      MAR          <= 16'h0000;
      MBR          <= 16'h0000;
      ex_pc        <= 8'h00;
      halt_program <= 1'b0;
      illegal_op   <= 1'b0;
      mem_timeout  <= 1'b0;
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= 8'h00;
    end else begin
      illegal_op <= 1'b0;
      mem_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'h00;
          if (flush) begin
            ex_valid <= 1'b0;
          end else begin
            if (ex_valid && ex_ready) begin
              ex_valid <= 1'b0;
            end
            if (accept) begin
              if (opcode > OP_LAST) begin
                illegal_op <= 1'b1;
              end else begin
                // Decoded fields load at accept; MBR follows once the read completes.
                OP_code <= opcode;
                value   <= operand;
                MAR     <= {8'h00, operand};
                ex_pc   <= if_pc;
                MBR     <= 16'h0000;
                if (is_mem_op(opcode)) begin
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= operand;
                  state       <= MEM_REQ;
                end else begin
                  ex_valid <= 1'b1;
                  if (opcode == OP_HALT) begin
                    halt_program <= 1'b1;
                    state        <= HALTED;
                  end
                end
              end
            end
          end
        end
        MEM_REQ: begin
          wait_cnt <= 8'h00;
          state    <= flush ? IDLE : MEM_WAIT;
        end
        MEM_WAIT: begin
          if (flush) begin
            wait_cnt <= 8'h00;
            state    <= IDLE;
          end else if (mem_rd_valid) begin
            MBR      <= mem_rd_data;
            ex_valid <= 1'b1;
            state    <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            MBR         <= 16'h0000;
            ex_valid    <= 1'b1;
            mem_timeout <= 1'b1;
            wait_cnt    <= 8'h00;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALTED: begin
          // Only reset leaves HALTED; flush is deliberately ignored here.
          if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_operand_fetch.sv
// Directed self-checking bench for decode_operand_fetch.
module tb_decode_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_ready;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_addr;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  OP_code;
  logic [7:0]  value;
  logic [15:0] MAR;
  logic [15:0] MBR;
  logic [7:0]  ex_pc;
  logic        halt_program;
  logic        illegal_op;
  logic        mem_timeout;

  int compared = 0;
  int mismatched = 0;

  decode_operand_fetch #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .OP_code(OP_code), .value(value),
    .MAR(MAR), .MBR(MBR), .ex_pc(ex_pc), .halt_program(halt_program),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [7:0] op, input logic [7:0] val,
                            input logic [15:0] mbr, input logic [7:0] pc);
    check({tag, ".ex_valid"}, {15'd0, ex_valid}, 16'd1);
    check({tag, ".OP_code"}, {8'd0, OP_code}, {8'd0, op});
    check({tag, ".value"}, {8'd0, value}, {8'd0, val});
    check({tag, ".MAR"}, MAR, {8'h00, val});
    check({tag, ".MBR"}, MBR, mbr);
    check({tag, ".ex_pc"}, {8'd0, ex_pc}, {8'd0, pc});
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = 16'h0000; if_pc = 8'h00;
    mem_rd_valid = 1'b0; mem_rd_data = 16'h0000; flush = 1'b0; ex_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst.ex_valid", {15'd0, ex_valid}, 16'd0);
    check("rst.OP_code", {8'd0, OP_code}, 16'd0);
    check("rst.MAR", MAR, 16'd0);
    check("rst.MBR", MBR, 16'd0);
    check("rst.flags", {13'd0, halt_program, illegal_op, mem_timeout}, 16'd0);
    check("rst.mem_rd", {7'd0, mem_rd_req, mem_rd_addr}, 16'd0);
    check("rst.if_ready", {15'd0, if_ready}, 16'd0);
    rst = 1'b1; #1;
    check("post_rst.if_ready", {15'd0, if_ready}, 16'd1);

    // ADDI stream, one per cycle
    ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = 16'h0505; if_pc = 8'h10; tick();
    check_word("addi0", 8'h05, 8'h05, 16'h0000, 8'h10);
    if_instr = 16'h0506; if_pc = 8'h11; tick();
    check_word("addi1", 8'h05, 8'h06, 16'h0000, 8'h11);
    if_instr = 16'h0507; if_pc = 8'h12; tick();
    check_word("addi2", 8'h05, 8'h07, 16'h0000, 8'h12);
    if_valid = 1'b0; tick();
    check("addi.drain", {15'd0, ex_valid}, 16'd0);

    // ADD with response in the second wait cycle
    if_valid = 1'b1; if_instr = 16'h0120; if_pc = 8'h20; tick();
    if_valid = 1'b0;
    check("add.req", {15'd0, mem_rd_req}, 16'd1);
    check("add.addr", {8'd0, mem_rd_addr}, 16'h0020);
    check("add.ex_valid_req", {15'd0, ex_valid}, 16'd0);
    check("add.if_ready_req", {15'd0, if_ready}, 16'd0);
    tick();
    check("add.req_once", {15'd0, mem_rd_req}, 16'd0);
    tick();
    mem_rd_valid = 1'b1; mem_rd_data = 16'hBEEF; tick();
    mem_rd_valid = 1'b0;
    check_word("add", 8'h01, 8'h20, 16'hBEEF, 8'h20);
    tick();
    check("add.retire", {15'd0, ex_valid}, 16'd0);

    // LOAD with no response: timeout after 15 wait cycles
    if_valid = 1'b1; if_instr = 16'h0310; if_pc = 8'h21; tick();
    if_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("load.no_early", {15'd0, ex_valid}, 16'd0);
    check("load.no_early_to", {15'd0, mem_timeout}, 16'd0);
    tick();
    check("load.timeout", {15'd0, mem_timeout}, 16'd1);
    check_word("load", 8'h03, 8'h10, 16'h0000, 8'h21);
    ex_ready = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 16'h1234; tick();
    mem_rd_valid = 1'b0;
    check("load.late_ignored", MBR, 16'h0000);
    check("load.held", {15'd0, ex_valid}, 16'd1);
    ex_ready = 1'b1; tick();
    check("load.retire", {15'd0, ex_valid}, 16'd0);
    check("load.timeout_sticky", {15'd0, mem_timeout}, 16'd1);

    // SUB held under backpressure, then retire+accept on the same edge
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 16'h0240; if_pc = 8'h30; tick();
    if_valid = 1'b0; tick();
    mem_rd_valid = 1'b1; mem_rd_data = 16'h5A5A; tick();
    mem_rd_valid = 1'b0;
    if_valid = 1'b1; if_instr = 16'h0501; if_pc = 8'h31; #1;
    for (int i = 0; i < 4; i++) begin
      check("sub.if_ready_stall", {15'd0, if_ready}, 16'd0);
      check_word("sub.hold", 8'h02, 8'h40, 16'h5A5A, 8'h30);
      tick();
    end
    ex_ready = 1'b1; #1;
    check("swap.if_ready", {15'd0, if_ready}, 16'd1);
    tick();
    check_word("swap", 8'h05, 8'h01, 16'h0000, 8'h31);
    if_valid = 1'b0; tick();

    // Illegal opcode
    if_valid = 1'b1; if_instr = 16'h09FF; if_pc = 8'h32; tick();
    if_valid = 1'b0;
    check("illegal.pulse", {15'd0, illegal_op}, 16'd1);
    check("illegal.dropped", {15'd0, ex_valid}, 16'd0);
    tick();
    check("illegal.one_cycle", {15'd0, illegal_op}, 16'd0);

    // Flush during MEM_REQ: stale response ignored
    if_valid = 1'b1; if_instr = 16'h0377; if_pc = 8'h33; tick();
    if_valid = 1'b0; flush = 1'b1; #1;
    check("flush.req_out", {15'd0, mem_rd_req}, 16'd1);
    check("flush.blocks_ready", {15'd0, if_ready}, 16'd0);
    tick();
    flush = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD; tick();
    mem_rd_valid = 1'b0;
    check("flush.stale_ignored", {15'd0, ex_valid}, 16'd0);
    check("flush.if_ready", {15'd0, if_ready}, 16'd1);

    // HALT, then only reset escapes
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 16'h0000; if_pc = 8'h40; tick();
    check("halt.flag", {15'd0, halt_program}, 16'd1);
    check_word("halt", 8'h00, 8'h00, 16'h0000, 8'h40);
    flush = 1'b1; if_instr = 16'h0505; #1;
    check("halt.if_ready_flush", {15'd0, if_ready}, 16'd0);
    tick();
    check("halt.flush_no_effect", {15'd0, ex_valid}, 16'd1);
    flush = 1'b0; ex_ready = 1'b1; tick();
    check("halt.retire", {15'd0, ex_valid}, 16'd0);
    tick();
    check("halt.if_ready_stuck", {15'd0, if_ready}, 16'd0);
    check("halt.no_accept", {15'd0, ex_valid}, 16'd0);
    check("halt.sticky", {15'd0, halt_program}, 16'd1);
    if_valid = 1'b0;
    rst = 1'b0; tick();
    check("rst2.flags", {13'd0, halt_program, illegal_op, mem_timeout}, 16'd0);
    rst = 1'b1; #1;
    check("rst2.if_ready", {15'd0, if_ready}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
